// File: rtl/shift_seq.sv
// Iterative shift sequencer: applies a 0..2^AMT_W-1 shift through an external
// combinational shifter that moves at most 3 positions per pass.
module shift_seq #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned AMT_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_dir,
    input  logic [AMT_W-1:0]  in_amt,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic [DATA_W-1:0] sh_a,
    output logic              sh_dir,
    output logic [1:0]        sh_amt,
    input  logic [DATA_W-1:0] sh_y
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  acc_q, acc_d;
    logic               dir_q, dir_d;
    logic [AMT_W-1:0]   rem_q, rem_d;
    logic [1:0]         step;
    logic [AMT_W-1:0]   rem_next;

    // step never exceeds rem, so rem_next cannot wrap
    assign step     = (rem_q >= AMT_W'(3)) ? 2'd3 : rem_q[1:0];
    assign rem_next = rem_q - AMT_W'(step);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            dir_q   <= 1'b0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            dir_q   <= dir_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        dir_d   = dir_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = in_data;
                    dir_d   = in_dir;
                    rem_d   = in_amt;
                    state_d = (in_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                acc_d = sh_y;
                rem_d = rem_next;
                if (rem_next == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags decode from registered state only
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        sh_amt    = (state_q == SHIFT) ? step : 2'd0;
        sh_a      = acc_q;
        sh_dir    = dir_q;
        out_data  = acc_q;
    end

endmodule

// File: tb/tb_shift_seq.sv
// Directed bench for shift_seq with a behavioural 8-bit shifter in the loop.
module tb_shift_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       in_dir;
    logic [3:0] in_amt;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       busy;
    logic [7:0] sh_a;
    logic       sh_dir;
    logic [1:0] sh_amt;
    logic [7:0] sh_y;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign sh_y = sh_dir ? (sh_a >> sh_amt) : (sh_a << sh_amt);

    shift_seq #(.DATA_W(8), .AMT_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_dir    (in_dir),
        .in_amt    (in_amt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .sh_a      (sh_a),
        .sh_dir    (sh_dir),
        .sh_amt    (sh_amt),
        .sh_y      (sh_y)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single edge; caller must know in_ready is high
    task automatic send(input logic [7:0] d, input logic dir, input logic [3:0] amt);
        in_valid = 1'b1;
        in_data  = d;
        in_dir   = dir;
        in_amt   = amt;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'hFF;
        in_dir    = 1'b1;
        in_amt    = 4'd7;
        out_ready = 1'b1;
        tick();
        tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_sh_a", sh_a, 8'h00);
        check("rst_sh_dir", sh_dir, 0);
        check("rst_sh_amt", sh_amt, 0);
        rst      = 1'b0;
        in_valid = 1'b0;

        // left by 1
        send(8'hAC, 1'b0, 4'd1);
        check("t1_sh_amt", sh_amt, 1);
        check("t1_busy", busy, 1);
        check("t1_in_ready", in_ready, 0);
        check("t1_out_valid_early", out_valid, 0);
        tick();
        check("t1_out_valid", out_valid, 1);
        check("t1_out_data", out_data, 8'h58);
        tick();
        check("t1_idle_in_ready", in_ready, 1);
        check("t1_idle_out_valid", out_valid, 0);

        // right by 5: passes of 3 then 2
        send(8'hAC, 1'b1, 4'd5);
        check("t2_sh_amt0", sh_amt, 3);
        check("t2_sh_dir", sh_dir, 1);
        tick();
        check("t2_sh_amt1", sh_amt, 2);
        check("t2_acc_mid", sh_a, 8'h15);
        check("t2_out_valid_early", out_valid, 0);
        tick();
        check("t2_out_valid", out_valid, 1);
        check("t2_out_data", out_data, 8'h05);
        tick();

        // zero amount still visits DONE
        send(8'hAC, 1'b0, 4'd0);
        check("t3_out_valid", out_valid, 1);
        check("t3_sh_amt", sh_amt, 0);
        check("t3_out_data", out_data, 8'hAC);
        tick();
        check("t3_idle", in_ready, 1);

        // left by 15: five passes of 3
        send(8'hFF, 1'b0, 4'd15);
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t4_sh_amt%0d", i), sh_amt, 3);
            check($sformatf("t4_out_valid_early%0d", i), out_valid, 0);
            tick();
        end
        check("t4_out_valid", out_valid, 1);
        check("t4_out_data", out_data, 8'h00);
        tick();

        // backpressure with a competing request held on the input
        out_ready = 1'b0;
        send(8'hAC, 1'b0, 4'd3);
        check("t5_sh_amt", sh_amt, 3);
        in_valid = 1'b1;
        in_data  = 8'h55;
        in_dir   = 1'b1;
        in_amt   = 4'd2;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t5_hold_valid%0d", i), out_valid, 1);
            check($sformatf("t5_hold_data%0d", i), out_data, 8'h60);
            check($sformatf("t5_hold_in_ready%0d", i), in_ready, 0);
            tick();
        end
        out_ready = 1'b1;
        check("t5_still_done", out_valid, 1);
        tick();
        check("t5_idle_in_ready", in_ready, 1);
        check("t5_idle_busy", busy, 0);
        tick();
        in_valid = 1'b0;
        check("t5_second_sh_a", sh_a, 8'h55);
        check("t5_second_sh_amt", sh_amt, 2);
        check("t5_second_sh_dir", sh_dir, 1);
        tick();
        check("t5_second_out_valid", out_valid, 1);
        check("t5_second_out_data", out_data, 8'h15);
        tick();

        // reset during the second SHIFT pass
        send(8'hAC, 1'b0, 4'd9);
        check("t6_pass1_amt", sh_amt, 3);
        tick();
        check("t6_pass2_amt", sh_amt, 3);
        check("t6_pass2_acc", sh_a, 8'h60);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_in_ready", in_ready, 1);
        check("t6_out_valid", out_valid, 0);
        check("t6_acc", sh_a, 8'h00);
        check("t6_busy", busy, 0);
        check("t6_sh_amt", sh_amt, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("t6_no_stale%0d", i), out_valid, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
